// File: rtl/fetch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_redirect_ctrl
//
// Purpose:
//   Sequences the fetch stage. Each cycle it merges branch/jump/jr redirects,
//   load-use stalls, exceptions and external interrupts into one legal
//   command: a PC / IF-ID write enable, a one-hot next-PC source select and
//   a trap status code for the trap vector logic.
//
// Parameters:
//   STALL_CYCLES  cycles the PC and IF/ID stay frozen per load-use hazard (1..15)
//   IRQ_HOLDOFF   cycles after an interrupt trap with no new interrupt (0..15)
//
// Ports:
//   clk              clock, all state updates on the rising edge
//   rst              asynchronous reset, active-high
//   irq              external interrupt request (level, rising edge latched)
//   exc_req          exception request pulse from decode/execute
//   load_use_hazard  load-use hazard detected this cycle
//   branch_taken     branch resolved taken
//   is_jump          j/jal in decode
//   is_jr            jr/jalr in decode
//   kernel_mode      PC[31] of the decode instruction; 1 masks interrupts
//   PC_IF_ID_Write   PC and IF/ID write enable
//   select_PC_next   {Z, J, JR} next-PC source, one-hot or 000
//   status           {interrupt, exception}: 00 normal, 10 irq, 01 exception
//   irq_ack          one-cycle pulse while the interrupt trap is issued
//   busy             high whenever the controller is not in RUN
// ---------------------------------------------------------------------------
module fetch_redirect_ctrl #(
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned IRQ_HOLDOFF  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       irq,
    input  logic       exc_req,
    input  logic       load_use_hazard,
    input  logic       branch_taken,
    input  logic       is_jump,
    input  logic       is_jr,
    input  logic       kernel_mode,
    output logic       PC_IF_ID_Write,
    output logic [2:0] select_PC_next,
    output logic [1:0] status,
    output logic       irq_ack,
    output logic       busy
);

    // The hazard cycle itself is the first frozen cycle, so the counter
    // only has to cover the remaining STALL_CYCLES-1 cycles.
    localparam logic [3:0] STALL_LOAD   = 4'(STALL_CYCLES - 1);
    localparam logic [3:0] HOLDOFF_LOAD = 4'(IRQ_HOLDOFF);
    localparam bit         NEED_STALL   = (STALL_CYCLES > 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        TRAP_EXC = 2'd2,
        TRAP_IRQ = 2'd3
    } state_t;

    state_t     state_q,       state_d;
    logic [3:0] stall_cnt_q,   stall_cnt_d;
    logic [3:0] holdoff_cnt_q, holdoff_cnt_d;
    logic       irq_pending_q, irq_pending_d;
    logic       irq_q,         irq_d;

    logic       redirect_req;
    logic [2:0] redirect_sel;
    logic       irq_edge;
    logic       irq_accept;
    logic [3:0] stall_cnt_dec;

    // Fixed-priority redirect decode: branch beats jump beats jr, so the
    // select can only ever be one-hot or all zero.
    always_comb begin
        redirect_req = branch_taken | is_jump | is_jr;
        redirect_sel = 3'b000;
        if (branch_taken) begin
            redirect_sel = 3'b100;
        end else if (is_jump) begin
            redirect_sel = 3'b010;
        end else if (is_jr) begin
            redirect_sel = 3'b001;
        end
    end

    // Rising-edge detector on the level-sensitive interrupt line.
    always_comb begin
        irq_d    = irq;
        irq_edge = irq & ~irq_q;
    end

    // Saturating decrement of the stall counter so it can never wrap.
    always_comb begin
        stall_cnt_dec = (stall_cnt_q == 4'd0) ? 4'd0 : stall_cnt_q - 4'd1;
    end

    // Main next-state and combinational output logic. The write enable and
    // select are zero-latency; a redirect is only issued in RUN where the
    // write enable is also high, so a redirect never meets a frozen PC.
    always_comb begin
        state_d        = state_q;
        stall_cnt_d    = stall_cnt_q;
        PC_IF_ID_Write = 1'b1;
        select_PC_next = 3'b000;
        irq_accept     = 1'b0;

        case (state_q)
            RUN: begin
                if (exc_req) begin
                    PC_IF_ID_Write = 1'b0;
                    state_d        = TRAP_EXC;
                end else if (redirect_req) begin
                    // The hazard-causing instruction is flushed by the
                    // redirect, so a simultaneous hazard is dropped.
                    select_PC_next = redirect_sel;
                end else if (load_use_hazard) begin
                    PC_IF_ID_Write = 1'b0;
                    stall_cnt_d    = STALL_LOAD;
                    state_d        = NEED_STALL ? STALL : RUN;
                end else if (irq_pending_q && !kernel_mode &&
                             (holdoff_cnt_q == 4'd0)) begin
                    PC_IF_ID_Write = 1'b0;
                    irq_accept     = 1'b1;
                    state_d        = TRAP_IRQ;
                end
            end

            STALL: begin
                PC_IF_ID_Write = 1'b0;
                if (exc_req) begin
                    // An exception abandons the stall entirely.
                    stall_cnt_d = 4'd0;
                    state_d     = TRAP_EXC;
                end else begin
                    stall_cnt_d = stall_cnt_dec;
                    if (stall_cnt_dec == 4'd0) begin
                        state_d = RUN;
                    end
                end
            end

            TRAP_EXC: begin
                state_d = RUN;
            end

            TRAP_IRQ: begin
                state_d = RUN;
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Interrupt pending flag and holdoff counter. A new edge in the same
    // cycle as an acceptance wins so that edge is not lost. The holdoff
    // reloads while the interrupt trap is issued and otherwise counts down
    // to zero in every state.
    always_comb begin
        irq_pending_d = irq_edge | (irq_pending_q & ~irq_accept);

        if (state_q == TRAP_IRQ) begin
            holdoff_cnt_d = HOLDOFF_LOAD;
        end else if (holdoff_cnt_q != 4'd0) begin
            holdoff_cnt_d = holdoff_cnt_q - 4'd1;
        end else begin
            holdoff_cnt_d = 4'd0;
        end
    end

    // Trap status, acknowledge and busy are decoded purely from the
    // registered state.
    always_comb begin
        status  = 2'b00;
        irq_ack = 1'b0;
        busy    = (state_q != RUN);
        if (state_q == TRAP_EXC) begin
            status = 2'b01;
        end else if (state_q == TRAP_IRQ) begin
            status  = 2'b10;
            irq_ack = 1'b1;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            stall_cnt_q   <= 4'd0;
            holdoff_cnt_q <= 4'd0;
            irq_pending_q <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            stall_cnt_q   <= stall_cnt_d;
            holdoff_cnt_q <= holdoff_cnt_d;
            irq_pending_q <= irq_pending_d;
            irq_q         <= irq_d;
        end
    end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Sequences the fetch stage: drives the PC write enable, the next-PC source select {Z, J, JR} and the trap status {interrupt, exception}.
- Arbitrates branch, jump and jr redirects, load-use stalls, exceptions and external interrupts into one legal command per cycle.
- Sits between hazard/branch resolution in ID/EX and the fetch stage.

Parameters:
- STALL_CYCLES, 1, number of cycles the PC and IF/ID are frozen per load-use hazard (1..15).
- IRQ_HOLDOFF, 4, cycles after an interrupt trap during which a new interrupt is not accepted (0..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- irq  in  1  external interrupt request, level; its rising edge sets a pending flag.
- exc_req  in  1  exception request from decode/execute, single-cycle pulse.
- load_use_hazard  in  1  load-use hazard detected this cycle.
- branch_taken  in  1  branch resolved taken.
- is_jump  in  1  j/jal in decode.
- is_jr  in  1  jr/jalr in decode.
- kernel_mode  in  1  PC[31] of the instruction in decode; 1 masks interrupts.
- PC_IF_ID_Write  out  1  PC and IF/ID write enable.
- select_PC_next  out  3  {Z, J, JR}, one-hot or 000.
- status  out  2  {interrupt, exception}: 00 normal, 10 interrupt, 01 exception.
- irq_ack  out  1  one-cycle pulse when the interrupt trap is issued.
- busy  out  1  1 when state != RUN.

Behaviour:
- Reset (async, rst=1): state=RUN, stall_cnt=0, holdoff_cnt=0, irq_pending=0, irq_q=0. Outputs: PC_IF_ID_Write=1, select_PC_next=000, status=00, irq_ack=0, busy=0.
- irq_pending is set when irq=1 and irq_q=0 (irq_q is irq delayed one cycle). It is cleared on interrupt acceptance; set wins if both happen in the same cycle.
- The redirect request has fixed priority branch_taken > is_jump > is_jr. The output is always one-hot (100/010/001) or 000; 011, 101 and 111 are never emitted.
- States: RUN, STALL, TRAP_EXC, TRAP_IRQ.
- RUN, priority per cycle:
  1. exc_req: write=0, select=000, next state TRAP_EXC.
  2. Redirect request: write=1, select=one-hot, stay RUN. load_use_hazard is ignored because the stalled instruction is flushed.
  3. load_use_hazard: write=0, select=000, load stall_cnt=STALL_CYCLES-1. Next state is STALL if STALL_CYCLES>1, else RUN.
  4. Interrupt acceptance, when irq_pending & ~kernel_mode & holdoff_cnt==0: write=0, clear irq_pending, next state TRAP_IRQ.
  5. Otherwise: write=1, select=000.
- STALL: write=0, select=000, stall_cnt decrements; go to RUN when stall_cnt==0 at a clock edge. exc_req aborts the stall: next state TRAP_EXC, stall_cnt=0. Redirects and interrupts are not accepted in STALL.
- TRAP_EXC: exactly one cycle. status=01, write=1, select=000, next state RUN.
- TRAP_IRQ: exactly one cycle. status=10, write=1, select=000, irq_ack=1, holdoff_cnt<=IRQ_HOLDOFF, next state RUN.
- Inside TRAP_* states, exc_req, redirects and hazards are ignored (the trap vector overrides them); irq edges still set irq_pending.
- holdoff_cnt decrements by 1 each cycle while nonzero, in every state, and saturates at 0.
- select_PC_next and write are combinational from state and inputs (zero latency). status and irq_ack depend only on state (registered).
- Invariant: select_PC_next != 000 only when PC_IF_ID_Write=1 and status=00. A redirect is therefore never dropped by a frozen PC.
- A redirect arriving in STALL or TRAP_* is the upstream's responsibility to hold; the controller does not queue it.
- Counter widths are 4 bits; no wrap-around past 0.

Test Plan:
- Reset mid-STALL: with STALL_CYCLES=2, pulse load_use_hazard, then raise rst in the next cycle -> outputs return immediately to write=1, select=000, status=00, busy=0.
- load_use_hazard for 1 cycle with STALL_CYCLES=2 -> write=0 for exactly 2 cycles, then 1; branch_taken with load_use_hazard simultaneously -> write=1, select=100, no stall.
- branch_taken=is_jump=is_jr=1 -> select=100; is_jump=is_jr=1 -> 010; only is_jr -> 001.
- irq rising with kernel_mode=0 -> next cycle write=0, following cycle status=10, irq_ack=1 for 1 cycle; second irq edge 2 cycles later -> not accepted until 4 cycles after the trap (IRQ_HOLDOFF=4).
- exc_req and irq edge together -> status=01 first; the interrupt trap (status=10) follows after TRAP_EXC once the pending flag is honoured; kernel_mode=1 holds irq_pending with no trap until kernel_mode=0.
- exc_req during STALL cycle 1 of 2 -> next cycle status=01, then RUN with write=1; stall not resumed.
